// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback (with supporting packages rv32i, core)
//  Description : Writeback stage in front of the register file write port.
//                Round-robin arbitration over SRC_CNT result sources, an
//                in-order circular result FIFO, and a two-state issue FSM
//                that holds one write request until the register file
//                reports done. Exports a pending-write mask for decode.
//
//  Ports       : clk, rst          clock, asynchronous active-high reset
//                en                stage enable (low freezes all state)
//                src_valid/addr/value/ready   per-source result handshake
//                write_rsp         register file response (done, valid)
//                write_req         register file request (en, reg_addr, value)
//                pending_mask      registers with buffered/in-flight writes
//                count             FIFO occupancy
//
//  Revision    : 1.0  initial release
// ============================================================================

package rv32i;
    localparam int reg_width = 32;
    localparam int reg_cnt   = 32;
endpackage

package core;
    typedef struct packed {
        logic                         en;
        logic [4:0]                   reg_addr;
        logic [rv32i::reg_width-1:0]  value;
    } rf_write_req_t;

    typedef struct packed {
        logic done;
        logic valid;
    } rf_write_rsp_t;

    localparam rf_write_req_t rf_write_req_rst = '{en: 1'b0, reg_addr: 5'd0, value: '0};
endpackage

module rf_writeback #(
    parameter int SRC_CNT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      en,
    input  logic [SRC_CNT-1:0]                        src_valid,
    input  logic [SRC_CNT-1:0][4:0]                   src_addr,
    input  logic [SRC_CNT-1:0][rv32i::reg_width-1:0]  src_value,
    output logic [SRC_CNT-1:0]                        src_ready,
    input  core::rf_write_rsp_t                       write_rsp,
    output core::rf_write_req_t                       write_req,
    output logic [rv32i::reg_cnt-1:0]                 pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]               count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SEL_W = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                   r_state;
    logic [c_PTR_W-1:0]           r_wr_ptr;
    logic [c_PTR_W-1:0]           r_rd_ptr;
    logic [c_CNT_W-1:0]           r_count;
    logic [c_SEL_W-1:0]           r_last_grant;
    logic [FIFO_DEPTH-1:0]        r_valid;
    logic [4:0]                   r_issue_addr;
    logic [rv32i::reg_width-1:0]  r_issue_value;

    logic [4:0]                   r_mem_addr  [FIFO_DEPTH];
    logic [rv32i::reg_width-1:0]  r_mem_value [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                         w_can_accept;
    logic                         w_grant_any;
    logic [c_SEL_W-1:0]           w_grant_idx;
    logic                         w_grant;
    logic                         w_push;
    logic                         w_pop;
    logic [c_PTR_W-1:0]           w_rd_next;
    logic [4:0]                   w_grant_addr;
    logic [rv32i::reg_width-1:0]  w_grant_value;
    logic                         w_unused;

    // Only the done flag of the response is meaningful to this stage.
    assign w_unused = write_rsp.valid;

    // rst is folded in so src_ready reads 0 for as long as reset is held,
    // not just after the next clock edge.
    assign w_can_accept = en && !rst && (r_count < c_CNT_W'(FIFO_DEPTH));

    // Round-robin search starting one past the last granted source.
    always_comb begin
        int idx;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        for (int k = 0; k < SRC_CNT; k++) begin
            idx = (int'(r_last_grant) + 1 + k) % SRC_CNT;
            if (!w_grant_any && src_valid[idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = c_SEL_W'(idx);
            end
        end
    end

    assign w_grant       = w_grant_any && w_can_accept;
    assign w_grant_addr  = src_addr[w_grant_idx];
    assign w_grant_value = src_value[w_grant_idx];

    // Writes to x0 complete the handshake but never occupy the buffer.
    assign w_push    = w_grant && (w_grant_addr != 5'd0);
    assign w_pop     = en && (r_state == c_ISSUE) && write_rsp.done;
    assign w_rd_next = r_rd_ptr + c_PTR_W'(1);

    always_comb begin
        src_ready = '0;
        if (w_grant) begin
            src_ready[w_grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result storage; contents are qualified by r_valid, so no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= w_grant_addr;
            r_mem_value[r_wr_ptr] <= w_grant_value;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, arbitration history and issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_last_grant  <= '0;
            r_valid       <= '0;
            r_issue_addr  <= '0;
            r_issue_value <= '0;
        end else if (en) begin
            if (w_grant) begin
                r_last_grant <= w_grant_idx;
            end

            // Push and pop never target the same slot: that would need the
            // FIFO to be both empty (nothing to pop) and full (no push).
            if (w_push) begin
                r_wr_ptr           <= r_wr_ptr + c_PTR_W'(1);
                r_valid[r_wr_ptr]  <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr           <= w_rd_next;
                r_valid[r_rd_ptr]  <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                c_IDLE: begin
                    if (r_count != '0) begin
                        r_issue_addr  <= r_mem_addr[r_rd_ptr];
                        r_issue_value <= r_mem_value[r_rd_ptr];
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (write_rsp.done) begin
                        // Chain straight into the next entry when one is
                        // already resident; an entry pushed in this same
                        // cycle is picked up from IDLE instead.
                        if (r_count > c_CNT_W'(1)) begin
                            r_issue_addr  <= r_mem_addr[w_rd_next];
                            r_issue_value <= r_mem_value[w_rd_next];
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign write_req.en       = en && (r_state == c_ISSUE);
    assign write_req.reg_addr = r_issue_addr;
    assign write_req.value    = r_issue_value;
    assign count              = r_count;

    // The entry under issue stays valid until popped, so it is covered here.
    always_comb begin
        pending_mask = '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
            if (r_valid[e]) begin
                pending_mask[r_mem_addr[e]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback
//  Description : Self-checking bench for rf_writeback. Expected retirements
//                are queued by the stimulus; a monitor pops and compares on
//                every completed register-file write. A small responder
//                models the register file, answering done one cycle after
//                a request is first seen, optionally stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_writeback;

    localparam int c_SRC   = 2;
    localparam int c_DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [c_SRC-1:0]         src_valid;
    logic [c_SRC-1:0][4:0]    src_addr;
    logic [c_SRC-1:0][31:0]   src_value;
    logic [c_SRC-1:0]         src_ready;
    core::rf_write_rsp_t      write_rsp;
    core::rf_write_req_t      write_req;
    logic [31:0]              pending_mask;
    logic [2:0]               count;

    always #5 clk = ~clk;

    rf_writeback #(
        .SRC_CNT    (c_SRC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .src_value    (src_value),
        .src_ready    (src_ready),
        .write_rsp    (write_rsp),
        .write_req    (write_req),
        .pending_mask (pending_mask),
        .count        (count)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] value;
    } wr_t;

    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic stall  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Inputs and responder act at posedge+1/+2; monitor samples at negedge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] req_word(input logic [4:0] a, input logic [31:0] v);
        core::rf_write_req_t r;
        r.en       = 1'b1;
        r.reg_addr = a;
        r.value    = v;
        return 64'(r);
    endfunction

    // Register file model: done one cycle after a request is first seen.
    initial begin
        logic prev;
        logic seen;
        seen      = 1'b0;
        write_rsp = '0;
        forever begin
            @(posedge clk);
            #1;
            prev           = write_rsp.done;
            write_rsp.done = 1'b0;
            if (rst) begin
                seen = 1'b0;
            end else if (prev) begin
                seen = write_req.en;
            end else if (seen && !stall) begin
                write_rsp.done = 1'b1;
            end else begin
                seen = write_req.en;
            end
            write_rsp.valid = write_rsp.done;
        end
    end

    // Scoreboard monitor: every completed write must match the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && en && write_req.en && write_rsp.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected: got addr=%0d value=0x%0h, expected no write",
                             write_req.reg_addr, write_req.value);
                end else begin
                    e = exp_q.pop_front();
                    check("retire_addr",  64'(write_req.reg_addr), 64'(e.addr));
                    check("retire_value", 64'(write_req.value),    64'(e.value));
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((count != 3'd0 || write_req.en) && n < 60) begin
            step();
            n++;
        end
        check(name, 64'(count), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int         n;
        logic [2:0] max_cnt;

        rst = 1'b1; en = 1'b1;
        src_valid = '0; src_addr = '0; src_value = '0;
        repeat (2) step();

        // ---------------- reset state ----------------
        src_valid = 2'b11; src_addr[0] = 5'd3; src_addr[1] = 5'd4;
        #1;
        check("rst_ready",   64'(src_ready),    64'(0));
        check("rst_req",     64'(write_req),    64'(core::rf_write_req_rst));
        check("rst_count",   64'(count),        64'(0));
        check("rst_pending", 64'(pending_mask), 64'(0));
        src_valid = '0;
        step();
        rst = 1'b0;
        step();

        // ---------------- single write ----------------
        src_valid = 2'b01; src_addr[0] = 5'd5; src_value[0] = 32'hDEADBEEF;
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        #1;
        check("single_ready", 64'(src_ready), 64'(2'b01));
        step();                                           // t+1
        src_valid = '0;
        check("single_count_t1",  64'(count),        64'(1));
        check("single_pend_t1",   64'(pending_mask), 64'(32'h20));
        check("single_req_en_t1", 64'(write_req.en), 64'(0));
        step();                                           // t+2
        check("single_req_t2",    64'(write_req),    req_word(5'd5, 32'hDEADBEEF));
        step();                                           // t+3
        check("single_pend_t3",   64'(pending_mask), 64'(32'h20));
        step();                                           // t+4
        check("single_pend_t4",   64'(pending_mask), 64'(0));
        check("single_count_t4",  64'(count),        64'(0));
        check("single_req_en_t4", 64'(write_req.en), 64'(0));

        // ---------------- contention: grants 1,0,1,0 ----------------
        do_reset();
        src_valid = 2'b11;
        src_addr[0] = 5'd10; src_value[0] = 32'h100;
        src_addr[1] = 5'd11; src_value[1] = 32'h200;
        exp_q.push_back('{5'd11, 32'h200});
        exp_q.push_back('{5'd10, 32'h100});
        exp_q.push_back('{5'd11, 32'h201});
        exp_q.push_back('{5'd10, 32'h101});
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("contend_ready_%0d", c), 64'(src_ready),
                  (c % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            step();
            if (c % 2 == 0) src_value[1] = src_value[1] + 32'd1;
            else            src_value[0] = src_value[0] + 32'd1;
        end
        src_valid = '0;
        drain("contend_drain");

        // ---------------- full FIFO ----------------
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_valid = 2'b01; src_addr[0] = 5'(i + 1); src_value[0] = 32'(i + 1);
            exp_q.push_back('{5'(i + 1), 32'(i + 1)});
            step();
        end
        src_addr[0] = 5'd6; src_value[0] = 32'h66;
        #1;
        check("full_count", 64'(count),     64'(4));
        check("full_ready", 64'(src_ready), 64'(0));
        stall = 1'b0;
        n = 0;
        while (!write_rsp.done && n < 20) begin
            step();
            n++;
        end
        check("full_done_seen",   64'(write_rsp.done), 64'(1));
        check("full_ready_pop",   64'(src_ready),      64'(0));
        check("full_count_pop",   64'(count),          64'(4));
        exp_q.push_back('{5'd6, 32'h66});
        step();
        check("full_ready_after", 64'(src_ready),      64'(2'b01));
        check("full_count_after", 64'(count),          64'(3));
        step();
        src_valid = '0;
        check("full_count_refill", 64'(count), 64'(4));
        max_cnt = count;
        n = 0;
        while ((count != 3'd0 || write_req.en) && n < 60) begin
            step();
            if (count > max_cnt) max_cnt = count;
            n++;
        end
        check("full_drain",     64'(count),   64'(0));
        check("full_max_count", 64'(max_cnt), 64'(4));

        // ---------------- x0 drop ----------------
        src_valid = 2'b01; src_addr[0] = 5'd0; src_value[0] = 32'h1;
        #1;
        check("x0_ready", 64'(src_ready), 64'(2'b01));
        step();
        src_valid = '0;
        check("x0_count",   64'(count),        64'(0));
        check("x0_pending", 64'(pending_mask), 64'(0));
        step();
        step();
        check("x0_req_en",  64'(write_req.en), 64'(0));

        // ---------------- enable freeze ----------------
        src_valid = 2'b01; src_addr[0] = 5'd9; src_value[0] = 32'h99;
        exp_q.push_back('{5'd9, 32'h99});
        step();
        src_valid = '0;
        step();                                           // request up
        check("freeze_req_before", 64'(write_req.en), 64'(1));
        en = 1'b0;
        src_valid = 2'b10; src_addr[1] = 5'd12; src_value[1] = 32'h12;
        #1;
        check("freeze_req_en", 64'(write_req.en), 64'(0));
        check("freeze_ready",  64'(src_ready),    64'(0));
        step();                                           // done arrives, ignored
        step();
        check("freeze_count",   64'(count),        64'(1));
        check("freeze_pending", 64'(pending_mask), 64'(32'h200));
        src_valid = '0;
        en = 1'b1;
        #1;
        check("freeze_represent", 64'(write_req), req_word(5'd9, 32'h99));
        drain("freeze_drain");

        // ---------------- WAW ordering ----------------
        src_valid = 2'b01; src_addr[0] = 5'd7; src_value[0] = 32'h11;
        exp_q.push_back('{5'd7, 32'h11});
        step();
        src_value[0] = 32'h22;
        exp_q.push_back('{5'd7, 32'h22});
        step();
        src_valid = '0;
        n = 0;
        while (count != 3'd0 && n < 30) begin
            check("waw_pending7_held", 64'(pending_mask[7]), 64'(1));
            step();
            n++;
        end
        check("waw_drain",          64'(count),           64'(0));
        check("waw_pending7_clear", 64'(pending_mask[7]), 64'(0));

        // ---------------- reset mid-ISSUE ----------------
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_valid = 2'b01; src_addr[0] = 5'(13 + i); src_value[0] = 32'(32'h130 + i);
            step();
        end
        src_valid = '0;
        check("rmi_req_en_before", 64'(write_req.en), 64'(1));
        check("rmi_count_before",  64'(count),        64'(3));
        rst = 1'b1;
        src_valid = 2'b01; src_addr[0] = 5'd3;
        #1;
        check("rmi_req_en",  64'(write_req.en), 64'(0));
        check("rmi_count",   64'(count),        64'(0));
        check("rmi_pending", 64'(pending_mask), 64'(0));
        check("rmi_ready",   64'(src_ready),    64'(0));
        src_valid = '0;
        step();
        rst = 1'b0;
        stall = 1'b0;
        step();
        src_valid = 2'b01; src_addr[0] = 5'd20; src_value[0] = 32'hCAFEF00D;
        exp_q.push_back('{5'd20, 32'hCAFEF00D});
        step();                                           // t+1
        src_valid = '0;
        check("rmi_req_en_t1", 64'(write_req.en), 64'(0));
        step();                                           // t+2
        check("rmi_req_t2", 64'(write_req), req_word(5'd20, 32'hCAFEF00D));
        drain("rmi_drain");

        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
